// File: rtl/pipeline_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake over a 1- or 2-entry circular skid buffer,
// with flush, a retirement counter and fixed bubble values on the outputs whenever the stage is empty.
module pipeline_wb_stage #(
   parameter int          DATA_W      = 32,
   parameter int          RN_W        = 5,
   parameter int          DEPTH       = 2,
   parameter logic [31:0] BUBBLE_PC   = 32'h1,
   parameter logic [31:0] BUBBLE_INST = 32'h0,
   parameter int          CNT_W       = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic              i_in_wreg,
   input  logic              i_in_m2reg,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [DATA_W-1:0] i_in_memout,
   input  logic [RN_W-1:0]   i_in_rn,
   input  logic [31:0]       i_in_pc,
   input  logic [31:0]       i_in_inst,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_out_wreg,
   output logic              o_out_m2reg,
   output logic [DATA_W-1:0] o_out_data,
   output logic [DATA_W-1:0] o_out_memout,
   output logic [RN_W-1:0]   o_out_rn,
   output logic [31:0]       o_out_pc,
   output logic [31:0]       o_out_inst,
   output logic [CNT_W-1:0]  o_retire_count
);

   localparam int PW = 2 + 2 * DATA_W + RN_W + 64;

   logic [1:0]       r_count;
   logic             r_head;
   logic             r_tail;
   logic [CNT_W-1:0] r_retire;
   logic [PW-1:0]    r_mem [0:1];

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_in_word;
   logic [PW-1:0]    w_head_word;

   // Pointers wrap modulo DEPTH; with a single entry they stay pinned at slot 0.
   function automatic logic next_ptr(input logic p);
      if (DEPTH == 2) begin
         return ~p;
      end else begin
         return 1'b0;
      end
   endfunction

   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = i_in_valid & w_in_ready & ~i_flush;
   assign w_pop       = w_out_valid & i_out_ready;
   assign w_in_word   = {i_in_wreg, i_in_m2reg, i_in_data, i_in_memout, i_in_rn, i_in_pc, i_in_inst};
   assign w_head_word = r_mem[r_head];

   // Two entries break the ready path from the consumer; one entry must pass ready through.
   always_comb begin
      if (DEPTH == 1) begin
         w_in_ready = (r_count == 2'd0) | i_out_ready;
      end else begin
         w_in_ready = (r_count < 2'd2);
      end
   end

   always_comb begin
      if (w_out_valid) begin
         o_out_wreg   = w_head_word[PW-1];
         o_out_m2reg  = w_head_word[PW-2];
         o_out_data   = w_head_word[PW-3 -: DATA_W];
         o_out_memout = w_head_word[PW-3-DATA_W -: DATA_W];
         o_out_rn     = w_head_word[RN_W+63 -: RN_W];
         o_out_pc     = w_head_word[63:32];
         o_out_inst   = w_head_word[31:0];
      end else begin
         o_out_wreg   = 1'b0;
         o_out_m2reg  = 1'b0;
         o_out_data   = {DATA_W{1'b0}};
         o_out_memout = {DATA_W{1'b0}};
         o_out_rn     = {RN_W{1'b0}};
         o_out_pc     = BUBBLE_PC;
         o_out_inst   = BUBBLE_INST;
      end
   end

   // A pop in a flush cycle still retires: the consumer already took the head.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count  <= 2'd0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
         r_retire <= {CNT_W{1'b0}};
      end else begin
         if (w_pop) begin
            r_retire <= r_retire + CNT_W'(1);
         end
         if (i_flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
         end else begin
            if (w_push) begin
               r_tail <= next_ptr(r_tail);
            end
            if (w_pop) begin
               r_head <= next_ptr(r_head);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Payload storage is not reset; the output mux hides stale entries.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_tail] <= w_in_word;
      end
   end

   assign o_in_ready     = w_in_ready;
   assign o_out_valid    = w_out_valid;
   assign o_retire_count = r_retire;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Directed bench for pipeline_wb_stage: a DEPTH=2 instance and a DEPTH=1 instance share stimulus.
module tb_pipeline_wb_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_wreg, in_m2reg, out_ready;
   logic [31:0] in_data, in_memout, in_pc, in_inst;
   logic [4:0]  in_rn;

   logic        in_ready, out_valid, out_wreg, out_m2reg;
   logic [31:0] out_data, out_memout, out_pc, out_inst;
   logic [4:0]  out_rn;
   logic [3:0]  retire;

   logic        d1_in_ready, d1_out_valid, d1_out_wreg, d1_out_m2reg;
   logic [31:0] d1_out_data, d1_out_memout, d1_out_pc, d1_out_inst;
   logic [4:0]  d1_out_rn;
   logic [3:0]  d1_retire;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_wb_stage #(.DEPTH(2), .CNT_W(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_wreg(in_wreg), .i_in_m2reg(in_m2reg), .i_in_data(in_data), .i_in_memout(in_memout),
      .i_in_rn(in_rn), .i_in_pc(in_pc), .i_in_inst(in_inst), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_out_wreg(out_wreg), .o_out_m2reg(out_m2reg), .o_out_data(out_data),
      .o_out_memout(out_memout), .o_out_rn(out_rn), .o_out_pc(out_pc), .o_out_inst(out_inst),
      .o_retire_count(retire)
   );

   pipeline_wb_stage #(.DEPTH(1), .CNT_W(4)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(d1_in_ready),
      .i_in_wreg(in_wreg), .i_in_m2reg(in_m2reg), .i_in_data(in_data), .i_in_memout(in_memout),
      .i_in_rn(in_rn), .i_in_pc(in_pc), .i_in_inst(in_inst), .o_out_valid(d1_out_valid),
      .i_out_ready(out_ready), .o_out_wreg(d1_out_wreg), .o_out_m2reg(d1_out_m2reg), .o_out_data(d1_out_data),
      .o_out_memout(d1_out_memout), .o_out_rn(d1_out_rn), .o_out_pc(d1_out_pc), .o_out_inst(d1_out_inst),
      .o_retire_count(d1_retire)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] d, input logic [31:0] pc);
      in_valid  = v;
      in_data   = d;
      in_pc     = pc;
      in_inst   = d ^ 32'h1234_0000;
      in_rn     = d[4:0];
      in_wreg   = 1'b1;
      in_m2reg  = 1'b0;
      in_memout = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_pc !== 32'h1) begin n_bad++; $display("FAIL reset_pc got %h want 00000001", out_pc); end
      n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h want 0", out_inst); end
      n_cmp++; if (out_wreg !== 1'b0) begin n_bad++; $display("FAIL reset_wreg got %0b want 0", out_wreg); end
      n_cmp++; if (retire !== 4'd0) begin n_bad++; $display("FAIL reset_retire got %0d want 0", retire); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_depth1();
      do_reset();
      #1;
      n_cmp++; if (d1_in_ready !== 1'b1) begin n_bad++; $display("FAIL d1_ready_empty got %0b want 1", d1_in_ready); end
      set_in(1'b1, 32'hA1, 32'h10);
      step();
      set_in(1'b0, 32'h0, 32'h0);
      #1;
      n_cmp++; if (d1_out_valid !== 1'b1) begin n_bad++; $display("FAIL d1_valid got %0b want 1", d1_out_valid); end
      n_cmp++; if (d1_in_ready !== 1'b0) begin n_bad++; $display("FAIL d1_ready_full_stall got %0b want 0", d1_in_ready); end
      n_cmp++; if (d1_out_data !== 32'hA1) begin n_bad++; $display("FAIL d1_data_a got %h want a1", d1_out_data); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (d1_in_ready !== 1'b1) begin n_bad++; $display("FAIL d1_ready_passthru got %0b want 1", d1_in_ready); end
      set_in(1'b1, 32'hB2, 32'h14);
      step();
      set_in(1'b0, 32'h0, 32'h0);
      n_cmp++; if (d1_out_data !== 32'hB2) begin n_bad++; $display("FAIL d1_data_b got %h want b2", d1_out_data); end
      n_cmp++; if (d1_retire !== 4'd1) begin n_bad++; $display("FAIL d1_retire1 got %0d want 1", d1_retire); end
      step();
      n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL d1_empty got %0b want 0", d1_out_valid); end
      n_cmp++; if (d1_retire !== 4'd2) begin n_bad++; $display("FAIL d1_retire2 got %0d want 2", d1_retire); end
      do_reset();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      set_in(1'b1, 32'hDEAD_BEEF, 32'h400);
      in_rn = 5'd7;
      step();
      set_in(1'b0, 32'h0, 32'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b want 1", out_valid); end
      n_cmp++; if (out_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_data got %h want deadbeef", out_data); end
      n_cmp++; if (out_rn !== 5'd7) begin n_bad++; $display("FAIL single_rn got %0d want 7", out_rn); end
      n_cmp++; if (out_wreg !== 1'b1) begin n_bad++; $display("FAIL single_wreg got %0b want 1", out_wreg); end
      n_cmp++; if (out_pc !== 32'h400) begin n_bad++; $display("FAIL single_pc got %h want 400", out_pc); end
      n_cmp++; if (out_inst !== 32'hCC99_BEEF) begin n_bad++; $display("FAIL single_inst got %h want cc99beef", out_inst); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty got %0b want 0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL single_bubble_data got %h want 0", out_data); end
      n_cmp++; if (out_pc !== 32'h1) begin n_bad++; $display("FAIL single_bubble_pc got %h want 1", out_pc); end
      n_cmp++; if (retire !== 4'd1) begin n_bad++; $display("FAIL single_retire got %0d want 1", retire); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_in(1'b1, 32'hA, 32'h100);
      in_wreg = 1'b0; in_m2reg = 1'b1; in_memout = 32'hCAFE;
      step();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one got %0b want 1", in_ready); end
      set_in(1'b1, 32'hB, 32'h104);
      step();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got %0b want 0", in_ready); end
      n_cmp++; if (out_m2reg !== 1'b1) begin n_bad++; $display("FAIL bp_m2reg got %0b want 1", out_m2reg); end
      n_cmp++; if (out_memout !== 32'hCAFE) begin n_bad++; $display("FAIL bp_memout got %h want cafe", out_memout); end
      n_cmp++; if (out_wreg !== 1'b0) begin n_bad++; $display("FAIL bp_wreg got %0b want 0", out_wreg); end
      set_in(1'b1, 32'hC, 32'h108);
      step();
      n_cmp++; if (out_data !== 32'hA) begin n_bad++; $display("FAIL bp_hold_head got %h want a", out_data); end
      set_in(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      step();
      n_cmp++; if (out_data !== 32'hB) begin n_bad++; $display("FAIL bp_second got %h want b", out_data); end
      n_cmp++; if (out_pc !== 32'h104) begin n_bad++; $display("FAIL bp_second_pc got %h want 104", out_pc); end
      n_cmp++; if (retire !== 4'd2) begin n_bad++; $display("FAIL bp_retire2 got %0d want 2", retire); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %0b want 0", out_valid); end
      n_cmp++; if (retire !== 4'd3) begin n_bad++; $display("FAIL bp_retire3 got %0d want 3", retire); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 32'h10 + i, 32'h200 + 4 * i);
         step();
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %0b want 1", i, out_valid); end
         n_cmp++; if (out_data !== 32'h10 + i) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, 32'h10 + i); end
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
      end
      set_in(1'b0, 32'h0, 32'h0);
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
      n_cmp++; if (retire !== 4'd11) begin n_bad++; $display("FAIL b2b_retire got %0d want 11", retire); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      set_in(1'b1, 32'h55, 32'h300);
      step();
      set_in(1'b1, 32'h66, 32'h304);
      step();
      flush = 1'b1; out_ready = 1'b1;
      set_in(1'b1, 32'h77, 32'h308);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_full_ready got %0b want 0", in_ready); end
      n_cmp++; if (out_data !== 32'h55) begin n_bad++; $display("FAIL flush_head got %h want 55", out_data); end
      step();
      flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got %0b want 0", out_valid); end
      n_cmp++; if (out_pc !== 32'h1) begin n_bad++; $display("FAIL flush_pc got %h want 1", out_pc); end
      n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL flush_inst got %h want 0", out_inst); end
      n_cmp++; if (retire !== 4'd12) begin n_bad++; $display("FAIL flush_retire got %0d want 12", retire); end
      set_in(1'b1, 32'h88, 32'h30C);
      step();
      flush = 1'b1;
      set_in(1'b1, 32'h99, 32'h310);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_one_ready got %0b want 1", in_ready); end
      step();
      flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop_input got %0b want 0", out_valid); end
      n_cmp++; if (retire !== 4'd12) begin n_bad++; $display("FAIL flush_no_pop got %0d want 12", retire); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stays_empty got %0b want 0", out_valid); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, 32'h40 + i, 32'h500 + 4 * i);
         step();
      end
      set_in(1'b0, 32'h0, 32'h0);
      step();
      n_cmp++; if (retire !== 4'd1) begin n_bad++; $display("FAIL wrap_retire got %0d want 1", retire); end
      out_ready = 1'b0;
      set_in(1'b1, 32'hE0, 32'h600);
      step();
      set_in(1'b1, 32'hE1, 32'h604);
      step();
      set_in(1'b0, 32'h0, 32'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL held_valid got %0b want 1", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL held_full got %0b want 0", in_ready); end
      reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
      step();
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %0b want 0", out_valid); end
      n_cmp++; if (retire !== 4'd0) begin n_bad++; $display("FAIL midreset_retire got %0d want 0", retire); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready got %0b want 1", in_ready); end
      n_cmp++; if (out_pc !== 32'h1) begin n_bad++; $display("FAIL midreset_pc got %h want 1", out_pc); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      test_reset();
      test_depth1();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_wrap_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
